// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding, requester IDs and a grant helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } stateT;

  typedef logic reqIdT;

  localparam reqIdT REQ_IF = 1'b0;
  localparam reqIdT REQ_D  = 1'b1;

  // One-hot grant vector: bit 0 = fetch, bit 1 = data.
  function automatic logic [1:0] oneHot(reqIdT id);
    return (id == REQ_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the arbiter.
// On a tie the side not granted last wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ifReq,
  input  logic       dReq,
  input  reqIdT      lastGnt,
  output logic [1:0] gnt
);

  // Combinational one-hot pick.
  always_comb begin
    gnt = 2'b00;
    unique case ({dReq, ifReq})
      2'b11: begin
        if (lastGnt == REQ_D) gnt = oneHot(REQ_IF);
        else                  gnt = oneHot(REQ_D);
      end
      2'b10:   gnt = oneHot(REQ_D);
      2'b01:   gnt = oneHot(REQ_IF);
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port.
// MEM_ARB_RR_EN selects round-robin ties instead of data-first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [DATA_W-1:0] ifAddr,
  output logic              ifGnt,
  output logic              ifValid,
  output logic [DATA_W-1:0] ifRdata,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [DATA_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  input  logic [3:0]        dBe,
  output logic              dGnt,
  output logic              dValid,
  output logic [DATA_W-1:0] dRdata,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic [3:0]        memBe,
  input  logic [DATA_W-1:0] memRdata,
  output logic              busy
);

  stateT             state;
  stateT             nextState;
  logic [3:0]        cnt;
  reqIdT             cur;
  reqIdT             lastGnt;
  logic [1:0]        pick;
  logic              take;
  logic [DATA_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              weQ;
  logic [3:0]        beQ;

  mem_arb_pick uPick (
    .ifReq   (ifReq),
    .dReq    (dReq),
    .lastGnt (lastGnt),
    .gnt     (pick)
  );

  assign take = (state == IDLE) && (|pick);

`ifdef MEM_ARB_RR_EN
  reqIdT lastQ;

  // Remember who was granted last; starts as fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lastQ <= REQ_IF;
    else if (take) lastQ <= pick[1] ? REQ_D : REQ_IF;
  end

  assign lastGnt = lastQ;
`else
  assign lastGnt = REQ_IF;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state and strobes.
  always_comb begin
    nextState = state;
    ifGnt     = 1'b0;
    dGnt      = 1'b0;
    ifValid   = 1'b0;
    dValid    = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWdata  = '0;
    memBe     = 4'h0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        ifGnt = ~rst & pick[0];
        dGnt  = ~rst & pick[1];
        if (|pick) nextState = ISSUE;
      end
      ISSUE: begin
        memReq    = 1'b1;
        memWe     = weQ;
        memAddr   = addrQ;
        memWdata  = wdataQ;
        memBe     = beQ;
        nextState = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) nextState = RESP;
      end
      RESP: begin
        ifValid   = (cur == REQ_IF);
        dValid    = (cur == REQ_D);
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Capture the winner, count latency, register read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= REQ_IF;
      addrQ   <= '0;
      wdataQ  <= '0;
      weQ     <= 1'b0;
      beQ     <= 4'h0;
      cnt     <= 4'd0;
      ifRdata <= '0;
      dRdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick[1]) begin
            cur    <= REQ_D;
            addrQ  <= dAddr;
            wdataQ <= dWdata;
            weQ    <= dWe;
            beQ    <= dBe;
          end else if (pick[0]) begin
            cur    <= REQ_IF;
            addrQ  <= ifAddr;
            wdataQ <= '0;
            weQ    <= 1'b0;
            beQ    <= 4'hF;
          end
        end
        ISSUE: cnt <= 4'(LATENCY);
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (cur == REQ_D) dRdata <= weQ ? '0 : memRdata;
            else              ifRdata <= memRdata;
          end
        end
        RESP: cnt <= 4'd0;
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, memory read latency in cycles from memReq to valid memRdata; legal range 1..15.
REQ-002 Parameter DATA_W, default 32, data and address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ifReq  input  1  fetch requester asks for a read.
REQ-006 ifAddr  input  32  fetch address.
REQ-007 ifGnt  output  1  one-cycle pulse when the fetch request is accepted.
REQ-008 ifValid  output  1  one-cycle pulse when ifRdata is valid.
REQ-009 ifRdata  output  32  fetch read data.
REQ-010 dReq, dWe  input  1 each  data request and write flag.
REQ-011 dAddr, dWdata  input  32 each  data address and write data.
REQ-012 dBe  input  4  data byte enables.
REQ-013 dGnt, dValid  output  1 each  data accept pulse and completion pulse.
REQ-014 dRdata  output  32  data read result.
REQ-015 memReq, memWe  output  1 each  memory strobe and write flag.
REQ-016 memAddr, memWdata  output  32 each  memory address and write data.
REQ-017 memBe  output  4  memory byte enables.
REQ-018 memRdata  input  32  memory read data, valid LATENCY cycles after memReq.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE with any request high, the winner SHALL get its Gnt in the same cycle T; its address, wdata, we and be SHALL be captured, and the state SHALL go to ISSUE.
REQ-022 In ISSUE (cycle T+1), memReq SHALL be high for exactly one cycle with the captured fields, a 4-bit counter SHALL load LATENCY, and the state SHALL go to WAIT.
REQ-023 WAIT SHALL decrement the counter. When it reaches 0 (cycle T+1+LATENCY), memRdata SHALL be registered and the state SHALL go to RESP.
REQ-024 RESP (cycle T+2+LATENCY) SHALL pulse the winner's Valid for one cycle with the registered data, then return to IDLE; the earliest next grant is T+3+LATENCY.
REQ-025 Fetch transactions SHALL always drive memWe=0 and memBe=4'hF.
REQ-026 A data write SHALL complete with a dValid pulse and dRdata=0.
REQ-027 Addresses and byte enables SHALL pass through unmodified; no alignment checks.
REQ-028 Default priority: on simultaneous ifReq and dReq, data wins.
REQ-029 A request dropped before its Gnt SHALL have no effect; request levels after Gnt SHALL be ignored until the transaction completes.
REQ-030 The non-winner's Gnt and Valid SHALL stay 0 throughout the transaction.
REQ-031 Rdata outputs SHALL hold their last value between Valid pulses.

Reset
REQ-032 rst SHALL force the state to IDLE, the counter to 0, and all outputs to 0, including the rdata outputs and the round-robin pointer.
REQ-033 Reset mid-transaction SHALL abandon it: no Valid pulse, and a late memRdata is ignored.

Configuration
REQ-034 With MEM_ARB_RR_EN defined, ties SHALL go to the requester not granted last; the pointer resets to "fetch last", so the first tie goes to data.
REQ-035 Without MEM_ARB_RR_EN, fixed data-over-fetch priority SHALL apply and no pointer flop SHALL exist.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum and requester IDs REQ_IF=0 and REQ_D=1.
REQ-037 The winner selection SHALL be a sub-module mem_arb_pick: inputs are the two requests and the last-grant ID; outputs are a one-hot grant.

Verification
REQ-038 LATENCY=1, ifReq with ifAddr=0x100 and memRdata=0x00000013 -> ifGnt at T, memReq at T+1 with memAddr=0x100, ifValid at T+3 with ifRdata=0x13.
REQ-039 Both requesters high, dAddr=0x200, dWe=1, dWdata=0xDEADBEEF, dBe=4'h3 -> dGnt first, memWe=1 with memBe=4'h3, dValid with dRdata=0; ifGnt at the next IDLE.
REQ-040 MEM_ARB_RR_EN defined and both requesters held high for 4 transactions -> grants in the order D, IF, D, IF; without the macro -> D, D, D, D.
REQ-041 LATENCY=4 -> Valid exactly 6 cycles after Gnt; busy high for cycles T+1..T+6.
REQ-042 rst asserted during WAIT -> all outputs 0 immediately; no Valid pulse; next grant in the first IDLE cycle after release.
REQ-043 ifReq pulsed for 1 cycle while busy -> no ifGnt is ever issued for it.
